// File: rtl/syncfifo_pkg.sv
// Shared definitions for the 5-queue scheduler: queue count, index width, FSM encoding.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package syncfifo_pkg;

    localparam int NQ = 5;   // queues in the shared FIFO
    localparam int QW = 3;   // width of a queue index

    typedef logic [QW-1:0] qid_t;

    typedef enum logic {
        IDLE  = 1'b0,        // no current queue
        SERVE = 1'b1         // bursting from cur
    } state_e;

    // last_q starts at the highest index so the first search begins at queue 0
    localparam qid_t LAST_Q_RST = 3'd4;

    // Increment a queue index modulo NQ
    function automatic qid_t mod5_inc(input qid_t q);
        return (q >= 3'd4) ? 3'd0 : q + 3'd1;
    endfunction

endpackage

// File: rtl/syncfifo_shared_sched_if.sv
// Bundle between the scheduler, the shared 5-queue FIFO and the downstream consumer.
// Latency: n/a (wires only).
// Backpressure: out_vld/out_ready handshake on the output side; pops are one-hot strobes.
// Ports: q_empty/q_dout from the FIFO, q_readout to the FIFO, en_mask per-queue enable,
//        out_vld/out_ready/out_data/out_qid to the consumer, pops running pop counter.
interface syncfifo_shared_sched_if
    import syncfifo_pkg::*;
#(
    parameter int WID = 32
) ();

    logic [NQ-1:0]           q_empty;
    logic [NQ-1:0][WID-1:0]  q_dout;
    logic [NQ-1:0]           q_readout;
    logic [NQ-1:0]           en_mask;
    logic                    out_vld;
    logic                    out_ready;
    logic [WID-1:0]          out_data;
    logic [QW-1:0]           out_qid;
    logic [15:0]             pops;

    // Scheduler side
    modport master (
        input  q_empty, q_dout, en_mask, out_ready,
        output q_readout, out_vld, out_data, out_qid, pops
    );

    // FIFO / consumer / control side
    modport slave (
        output q_empty, q_dout, en_mask, out_ready,
        input  q_readout, out_vld, out_data, out_qid, pops
    );

endinterface

// File: rtl/rr_pick5.sv
// Rotating find-first: first set bit of eligible scanning start, start+1, ... modulo 5.
// Latency: combinational.
// Backpressure: none.
// Ports: eligible[4:0] candidate mask, start[2:0] first index tried (0..4),
//        idx[2:0] chosen queue, found set when any candidate exists.
module rr_pick5
    import syncfifo_pkg::*;
(
    input  logic [NQ-1:0] eligible,
    input  qid_t          start,
    output qid_t          idx,
    output logic          found
);

    qid_t cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = start;
        for (int k = 0; k < NQ; k++) begin
            if (!found && eligible[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
            cand = mod5_inc(cand);
        end
    end

endmodule

// File: rtl/syncfifo_shared_sched.sv
// Burst round-robin pop scheduler for a shared 5-queue FIFO with a one-word output register.
// Latency: 1 cycle from q_readout pulse to out_vld/out_data/out_qid.
// Backpressure: pops only when the output register is empty or draining; held stable while out_ready=0.
// Ports: clk, rst (async, active-high), softreset (sync clear), bus (master modport of
//        syncfifo_shared_sched_if carrying FIFO flags/data/pop strobes and the output handshake).
module syncfifo_shared_sched
    import syncfifo_pkg::*;
#(
    parameter int WID   = 32,
    parameter int BURST = 4     // 1..15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    softreset,
    syncfifo_shared_sched_if.master bus
);

    state_e          state_q, state_d;
    qid_t            cur_q, cur_d;
    qid_t            last_q_q, last_q_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic            out_vld_q, out_vld_d;
    logic [WID-1:0]  out_data_q, out_data_d;
    qid_t            out_qid_q, out_qid_d;
    logic [15:0]     pops_q, pops_d;

    logic [NQ-1:0]   elig;
    logic            can_pop;
    logic            stay;
    qid_t            pick_start;
    qid_t            pick_idx;
    logic            pick_found;
    logic            pop_vld;
    qid_t            pop_idx;

    assign elig = ~bus.q_empty & bus.en_mask;

    // Pops are suppressed while any clear is pending so the FIFO loses nothing.
    assign can_pop = (~out_vld_q | bus.out_ready) & ~softreset & ~rst;

    assign stay = (state_q == SERVE) && elig[cur_q] && (bcnt_q < 4'(BURST));

    // In SERVE the search begins after cur and reaches cur last; from IDLE after last_q.
    assign pick_start = (state_q == SERVE) ? mod5_inc(cur_q) : mod5_inc(last_q_q);

    rr_pick5 u_pick (
        .eligible (elig),
        .start    (pick_start),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_q_d   = last_q_q;
        bcnt_d     = bcnt_q;
        pop_vld    = 1'b0;
        pop_idx    = cur_q;

        if (can_pop) begin
            if (stay) begin
                pop_vld = 1'b1;
                pop_idx = cur_q;
                bcnt_d  = bcnt_q + 4'd1;
            end else if (pick_found) begin
                pop_vld = 1'b1;
                pop_idx = pick_idx;
                cur_d   = pick_idx;
                bcnt_d  = 4'd1;
                state_d = SERVE;
            end else if (state_q == SERVE) begin
                // Nothing to serve: remember where we were for the next search.
                state_d  = IDLE;
                last_q_d = cur_q;
                bcnt_d   = 4'd0;
            end
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_qid_d  = out_qid_q;
        if (pop_vld) begin
            out_vld_d  = 1'b1;
            out_data_d = bus.q_dout[pop_idx];
            out_qid_d  = pop_idx;
        end else if (bus.out_ready) begin
            out_vld_d  = 1'b0;
        end
    end

    assign pops_d = pops_q + {15'd0, pop_vld};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            last_q_q   <= LAST_Q_RST;
            bcnt_q     <= 4'd0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_qid_q  <= '0;
            pops_q     <= 16'd0;
        end else if (softreset) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            last_q_q   <= LAST_Q_RST;
            bcnt_q     <= 4'd0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_qid_q  <= '0;
            pops_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q_q   <= last_q_d;
            bcnt_q     <= bcnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_qid_q  <= out_qid_d;
            pops_q     <= pops_d;
        end
    end

    assign bus.q_readout = pop_vld ? (5'b00001 << pop_idx) : 5'b00000;
    assign bus.out_vld   = out_vld_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_qid   = out_qid_q;
    assign bus.pops      = pops_q;

endmodule

// File: tb/tb_syncfifo_shared_sched.sv
// Directed bench for syncfifo_shared_sched with a behavioural 5-queue FIFO model.
// Latency: checks the 1-cycle pop-to-output path.
// Backpressure: exercises out_ready stalls.
module tb_syncfifo_shared_sched;
    import syncfifo_pkg::*;

    localparam int WID = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic softreset = 1'b0;

    always #5 clk = ~clk;

    syncfifo_shared_sched_if #(.WID(WID)) bus ();

    syncfifo_shared_sched #(.WID(WID), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .softreset (softreset),
        .bus       (bus)
    );

    int cnt  [NQ];
    int head [NQ];
    int total = 0;
    int bad   = 0;

    function automatic logic [WID-1:0] mkdat(input int q, input int h);
        logic [7:0]  qb;
        logic [15:0] hb;
        qb = 8'(q);
        hb = 16'(h);
        return {qb, 8'hC3, hb};
    endfunction

    function automatic logic [4:0] onehot(input int q);
        return 5'(1 << q);
    endfunction

    task automatic drive_q();
        for (int i = 0; i < NQ; i++) begin
            bus.q_empty[i] = (cnt[i] <= 0);
            bus.q_dout[i]  = mkdat(i, head[i]);
        end
    endtask

    // One clock: present FIFO state, sample the pop strobe, advance the FIFO model.
    task automatic step(output logic [4:0] rd);
        drive_q();
        #1;
        rd = bus.q_readout;
        @(posedge clk);
        for (int i = 0; i < NQ; i++) begin
            if (rd[i]) begin
                cnt[i]  = cnt[i] - 1;
                head[i] = head[i] + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        softreset   = 1'b0;
        bus.out_ready = 1'b1;
        bus.en_mask = 5'b11111;
        for (int i = 0; i < NQ; i++) begin
            cnt[i]  = 0;
            head[i] = 0;
        end
        drive_q();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.en_mask   = 5'b11111;
        for (int i = 0; i < NQ; i++) begin
            cnt[i]  = 0;
            head[i] = 0;
        end
        cnt[0] = 3;
        drive_q();
        #1;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%b exp=0", bus.out_vld); end
        total++; if (bus.out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        total++; if (bus.out_qid !== 3'd0) begin bad++; $display("FAIL reset_out_qid got=%0d exp=0", bus.out_qid); end
        total++; if (bus.q_readout !== 5'b0) begin bad++; $display("FAIL reset_q_readout got=%b exp=00000", bus.q_readout); end
        total++; if (bus.pops !== 16'd0) begin bad++; $display("FAIL reset_pops got=%0d exp=0", bus.pops); end
        @(negedge clk);
        cnt[0] = 0;
        rst = 1'b0;
    endtask

    task automatic test_two_queues();
        int exp_q [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
        logic [4:0]     rd;
        logic [WID-1:0] ed;
        do_reset();
        cnt[0] = 6;
        cnt[2] = 6;
        for (int k = 0; k < 12; k++) begin
            ed = mkdat(exp_q[k], head[exp_q[k]]);
            step(rd);
            total++;
            if (rd !== onehot(exp_q[k])) begin
                bad++; $display("FAIL two_q_pop k=%0d got=%b exp=%b", k, rd, onehot(exp_q[k]));
            end
            total++;
            if (bus.out_vld !== 1'b1 || bus.out_qid !== 3'(exp_q[k]) || bus.out_data !== ed) begin
                bad++; $display("FAIL two_q_out k=%0d got=%b/%0d/%h exp=1/%0d/%h",
                                k, bus.out_vld, bus.out_qid, bus.out_data, exp_q[k], ed);
            end
        end
        step(rd);
        total++; if (rd !== 5'b0) begin bad++; $display("FAIL two_q_drain_pop got=%b exp=00000", rd); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL two_q_vld_fall got=%b exp=0", bus.out_vld); end
        total++; if (bus.pops !== 16'd12) begin bad++; $display("FAIL two_q_pops got=%0d exp=12", bus.pops); end
    endtask

    task automatic test_single_queue();
        logic [4:0]     rd;
        logic [WID-1:0] ed;
        do_reset();
        cnt[3] = 10;
        for (int k = 0; k < 10; k++) begin
            ed = mkdat(3, k);
            step(rd);
            total++;
            if (rd !== 5'b01000 || bus.out_data !== ed || bus.out_vld !== 1'b1) begin
                bad++; $display("FAIL single_q k=%0d got=%b/%h exp=01000/%h", k, rd, bus.out_data, ed);
            end
        end
        step(rd);
        total++; if (rd !== 5'b0) begin bad++; $display("FAIL single_q_extra_pop got=%b exp=00000", rd); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL single_q_vld_fall got=%b exp=0", bus.out_vld); end
        total++; if (bus.pops !== 16'd10) begin bad++; $display("FAIL single_q_pops got=%0d exp=10", bus.pops); end
    endtask

    task automatic test_backpressure();
        logic [4:0]     rd;
        logic [WID-1:0] ed0;
        logic [WID-1:0] ed1;
        do_reset();
        cnt[1] = 5;
        ed0 = mkdat(1, 0);
        ed1 = mkdat(1, 1);
        step(rd);
        total++; if (rd !== 5'b00010) begin bad++; $display("FAIL bp_first_pop got=%b exp=00010", rd); end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(rd);
            total++;
            if (rd !== 5'b0 || bus.out_vld !== 1'b1 || bus.out_data !== ed0 || bus.out_qid !== 3'd1) begin
                bad++; $display("FAIL bp_hold k=%0d got=%b/%b/%h/%0d exp=00000/1/%h/1",
                                k, rd, bus.out_vld, bus.out_data, bus.out_qid, ed0);
            end
        end
        bus.out_ready = 1'b1;
        step(rd);
        total++; if (rd !== 5'b00010) begin bad++; $display("FAIL bp_resume_pop got=%b exp=00010", rd); end
        total++; if (bus.out_data !== ed1) begin bad++; $display("FAIL bp_resume_data got=%h exp=%h", bus.out_data, ed1); end
    endtask

    task automatic test_mask_mid_burst();
        logic [4:0] rd;
        do_reset();
        cnt[1] = 4;
        cnt[4] = 3;
        step(rd);
        total++; if (rd !== 5'b00010) begin bad++; $display("FAIL mask_pop1 got=%b exp=00010", rd); end
        step(rd);
        total++; if (rd !== 5'b00010) begin bad++; $display("FAIL mask_pop2 got=%b exp=00010", rd); end
        bus.en_mask = 5'b11101;
        step(rd);
        total++; if (rd !== 5'b10000) begin bad++; $display("FAIL mask_switch_pop got=%b exp=10000", rd); end
        total++;
        if (bus.out_qid !== 3'd4 || bus.out_data !== mkdat(4, 0)) begin
            bad++; $display("FAIL mask_switch_out got=%0d/%h exp=4/%h", bus.out_qid, bus.out_data, mkdat(4, 0));
        end
    endtask

    task automatic test_rst_mid_burst();
        logic [4:0] rd;
        int         ok;
        do_reset();
        cnt[3] = 5;
        cnt[1] = 2;
        bus.en_mask = 5'b01000;
        ok = 1;
        for (int k = 0; k < 3; k++) begin
            step(rd);
            if (rd !== 5'b01000) ok = 0;
        end
        total++; if (ok != 1 || bus.out_vld !== 1'b1) begin bad++; $display("FAIL rst_burst_setup ok=%0d vld=%b exp=1/1", ok, bus.out_vld); end
        bus.en_mask = 5'b11111;
        #2;
        rst = 1'b1;
        drive_q();
        #1;
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL rst_mid_vld got=%b exp=0", bus.out_vld); end
        total++; if (bus.pops !== 16'd0) begin bad++; $display("FAIL rst_mid_pops got=%0d exp=0", bus.pops); end
        total++; if (bus.q_readout !== 5'b0) begin bad++; $display("FAIL rst_mid_readout got=%b exp=00000", bus.q_readout); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(rd);
        total++; if (rd !== 5'b00010) begin bad++; $display("FAIL rst_first_pop got=%b exp=00010", rd); end
    endtask

    task automatic test_wrap_softreset();
        logic [4:0] rd;
        do_reset();
        cnt[0] = 70000;
        for (int k = 0; k < 65534; k++) step(rd);
        total++; if (bus.pops !== 16'hFFFE) begin bad++; $display("FAIL wrap_pre got=%h exp=fffe", bus.pops); end
        for (int k = 0; k < 3; k++) step(rd);
        total++; if (bus.pops !== 16'd1) begin bad++; $display("FAIL wrap_post got=%0d exp=1", bus.pops); end
        softreset = 1'b1;
        drive_q();
        #1;
        total++; if (bus.q_readout !== 5'b0) begin bad++; $display("FAIL sreset_readout got=%b exp=00000", bus.q_readout); end
        @(posedge clk);
        @(negedge clk);
        softreset = 1'b0;
        total++; if (bus.pops !== 16'd0) begin bad++; $display("FAIL sreset_pops got=%0d exp=0", bus.pops); end
        total++; if (bus.out_vld !== 1'b0) begin bad++; $display("FAIL sreset_vld got=%b exp=0", bus.out_vld); end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL sreset_state got=%0d exp=0", dut.state_q); end
        total++; if (dut.bcnt_q !== 4'd0) begin bad++; $display("FAIL sreset_bcnt got=%0d exp=0", dut.bcnt_q); end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        bus.en_mask   = 5'b11111;
        for (int i = 0; i < NQ; i++) begin
            cnt[i]  = 0;
            head[i] = 0;
        end
        drive_q();
        test_reset();
        test_two_queues();
        test_single_queue();
        test_backpressure();
        test_mask_mid_burst();
        test_rst_mid_burst();
        test_wrap_softreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
